// File: rtl/prog_mux_bank.sv
// prog_mux_bank: scan-configured bank of muxes with double-buffered, validated commit
module prog_mux_bank #(
    parameter int INPUTS  = 4,
    parameter int OUTPUTS = 2,
    parameter int INV_EN  = 1
) (
    input  logic               prog_clk,
    input  logic               prog_rst_n,
    input  logic               prog_en,
    input  logic               prog_in,
    output logic               prog_out,
    input  logic               prog_commit,
    output logic               prog_ready,
    output logic               prog_err,
    input  logic [INPUTS-1:0]  mux_in,
    output logic [OUTPUTS-1:0] mux_out
);
    localparam int SEL_W     = $clog2(INPUTS);
    localparam int IN_W      = 2 ** SEL_W;
    localparam int CH_BITS   = SEL_W + INV_EN;
    localparam int CHAIN_LEN = OUTPUTS * CH_BITS;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);
    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_LOADING = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    logic [CHAIN_LEN-1:0] shadow;
    logic [CHAIN_LEN-1:0] live;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           state;
    logic [IN_W-1:0]      in_ext;

    always_comb state = cnt == '0 ? S_EMPTY : cnt < CNT_FULL ? S_LOADING : cnt == CNT_FULL ? S_FULL : S_OVER;

    assign prog_ready = state == S_FULL;
    assign prog_out   = shadow[CHAIN_LEN-1];
    // unused upper inputs of a non-power-of-2 mux read as constant 0
    assign in_ext     = IN_W'(mux_in);

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            shadow   <= '0;
            live     <= '0;
            cnt      <= '0;
            prog_err <= 1'b0;
        end else if (prog_commit) begin
            if (state == S_FULL) live <= shadow;
            prog_err <= state != S_FULL;
            cnt      <= '0;
        end else if (prog_en) begin
            shadow <= CHAIN_LEN'({shadow, prog_in});
            cnt    <= cnt == CNT_SAT ? cnt : cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_ch
        logic [SEL_W-1:0] sel;
        logic             inv;
        assign sel = live[k*CH_BITS +: SEL_W];
        if (INV_EN != 0) begin : g_inv
            assign inv = live[k*CH_BITS+SEL_W];
        end else begin : g_noinv
            assign inv = 1'b0;
        end
        assign mux_out[k] = in_ext[sel] ^ inv;
    end
endmodule
